// File: rtl/point_multiplier_seq_if.sv
// Request/response bundle for point_multiplier_seq: start/operands in, busy/done/result out.
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

interface point_multiplier_seq_if #(
    parameter int WIDTH = `DATAWIDTH
);
    logic             start;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] Qx;
    logic [WIDTH-1:0] Qy;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Rx_out;
    logic [WIDTH-1:0] Ry_out;

    modport master (
        output start, n, Qx, Qy,
        input  busy, done, Rx_out, Ry_out
    );

    modport slave (
        input  start, n, Qx, Qy,
        output busy, done, Rx_out, Ry_out
    );
endinterface

// File: rtl/point_multiplier_seq.sv
// Sequential MSB-first double-and-add scalar multiplier sharing one PointAdder,
// plus the combinational affine PointAdder it drives (infinity encoded as (0,0)).
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

module PointAdder #(
    parameter int          WIDTH   = `DATAWIDTH,
    parameter int unsigned PRIME   = 17,
    parameter int unsigned CURVE_A = 2
) (
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] y3
);
    typedef logic [2*WIDTH-1:0] wide_t;

    function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        wide_t p;
        p = wide_t'(a) * wide_t'(b);
        return WIDTH'(p % wide_t'(PRIME));
    endfunction

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        wide_t s;
        s = wide_t'(a) + wide_t'(b);
        return WIDTH'(s % wide_t'(PRIME));
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        wide_t s;
        s = wide_t'(a) + wide_t'(PRIME) - wide_t'(b);
        return WIDTH'(s % wide_t'(PRIME));
    endfunction

    // Fermat inverse a^(p-2); operands are already reduced mod p
    function automatic logic [WIDTH-1:0] mod_inv(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] base;
        logic [WIDTH-1:0] e;
        result = WIDTH'(1);
        base   = a;
        e      = WIDTH'(PRIME - 2);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (e[i]) result = mod_mul(result, base);
            base = mod_mul(base, base);
        end
        return result;
    endfunction

    logic             p1_inf;
    logic             p2_inf;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic [WIDTH-1:0] lam;
    logic [WIDTH-1:0] xr;

    assign p1_inf = (x1 == '0) && (y1 == '0);
    assign p2_inf = (x2 == '0) && (y2 == '0);

    always_comb begin
        x3  = x1;
        y3  = y1;
        num = '0;
        den = '0;
        lam = '0;
        xr  = '0;
        if (p1_inf) begin
            x3 = x2;
            y3 = y2;
        end else if (p2_inf) begin
            x3 = x1;
            y3 = y1;
        end else if ((x1 == x2) && (mod_add(y1, y2) == '0)) begin
            x3 = '0;
            y3 = '0;
        end else begin
            if (x1 == x2) begin
                num = mod_add(mod_mul(WIDTH'(3), mod_mul(x1, x1)), WIDTH'(CURVE_A));
                den = mod_add(y1, y1);
            end else begin
                num = mod_sub(y2, y1);
                den = mod_sub(x2, x1);
            end
            lam = mod_mul(num, mod_inv(den));
            xr  = mod_sub(mod_sub(mod_mul(lam, lam), x1), x2);
            x3  = xr;
            y3  = mod_sub(mod_mul(lam, mod_sub(x1, xr)), y1);
        end
    end
endmodule

module point_multiplier_seq #(
    parameter int WIDTH              = `DATAWIDTH,
    parameter bit SKIP_LEADING_ZEROS = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    point_multiplier_seq_if.slave bus
);
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DBL, ADD, FIN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] r_x, r_y, r_x_n, r_y_n;
    logic [WIDTH-1:0] n_q, qx_q, qy_q;
    logic [WIDTH-1:0] rx_q, ry_q;
    logic [IDXW-1:0]  idx, idx_n, msb_pos;
    logic             load;
    logic [WIDTH-1:0] op_x, op_y, sum_x, sum_y;

    assign op_x = (state == ADD) ? qx_q : r_x;
    assign op_y = (state == ADD) ? qy_q : r_y;

    PointAdder #(.WIDTH(WIDTH)) u_adder (
        .x1(r_x),
        .y1(r_y),
        .x2(op_x),
        .y2(op_y),
        .x3(sum_x),
        .y3(sum_y)
    );

    always_comb begin
        msb_pos = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus.n[i]) msb_pos = IDXW'(i);
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        r_x_n   = r_x;
        r_y_n   = r_y;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load  = 1'b1;
                    r_x_n = '0;
                    r_y_n = '0;
                    if (!SKIP_LEADING_ZEROS) begin
                        idx_n   = IDXW'(WIDTH - 1);
                        state_n = DBL;
                    end else if (bus.n == '0) begin
                        idx_n   = '0;
                        state_n = FIN;
                    end else begin
                        idx_n   = msb_pos;
                        state_n = DBL;
                    end
                end
            end
            DBL: begin
                r_x_n = sum_x;
                r_y_n = sum_y;
                if (n_q[idx]) begin
                    state_n = ADD;
                end else if (idx == '0) begin
                    state_n = FIN;
                end else begin
                    idx_n = idx - 1'b1;
                end
            end
            ADD: begin
                r_x_n = sum_x;
                r_y_n = sum_y;
                if (idx == '0) begin
                    state_n = FIN;
                end else begin
                    idx_n   = idx - 1'b1;
                    state_n = DBL;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Result registers load on entry to FIN so they are already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            r_x   <= '0;
            r_y   <= '0;
            n_q   <= '0;
            qx_q  <= '0;
            qy_q  <= '0;
            rx_q  <= '0;
            ry_q  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            r_x   <= r_x_n;
            r_y   <= r_y_n;
            if (load) begin
                n_q  <= bus.n;
                qx_q <= bus.Qx;
                qy_q <= bus.Qy;
                rx_q <= '0;
                ry_q <= '0;
            end else if ((state_n == FIN) && (state != FIN)) begin
                rx_q <= r_x_n;
                ry_q <= r_y_n;
            end
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == FIN);
    assign bus.Rx_out = rx_q;
    assign bus.Ry_out = ry_q;
endmodule

// File: tb/tb_point_multiplier_seq.sv
// Directed bench for point_multiplier_seq on y^2 = x^3 + 2x + 2 mod 17, G = (5,1), group order 19.
module tb_point_multiplier_seq;
    logic clk;
    logic rst;
    int   checks;
    int   passes;

    point_multiplier_seq_if #(.WIDTH(8)) bus0 ();
    point_multiplier_seq_if #(.WIDTH(8)) bus1 ();

    point_multiplier_seq #(.WIDTH(8), .SKIP_LEADING_ZEROS(1'b1)) dut_skip (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    point_multiplier_seq #(.WIDTH(8), .SKIP_LEADING_ZEROS(1'b0)) dut_full (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input bit sel, input logic st, input logic [7:0] nn,
                         input logic [7:0] qx, input logic [7:0] qy);
        if (sel) begin
            bus1.start = st; bus1.n = nn; bus1.Qx = qx; bus1.Qy = qy;
        end else begin
            bus0.start = st; bus0.n = nn; bus0.Qx = qx; bus0.Qy = qy;
        end
    endtask

    task automatic sample(input bit sel, output logic b, output logic d,
                          output logic [7:0] rx, output logic [7:0] ry);
        b  = sel ? bus1.busy   : bus0.busy;
        d  = sel ? bus1.done   : bus0.done;
        rx = sel ? bus1.Rx_out : bus0.Rx_out;
        ry = sel ? bus1.Ry_out : bus0.Ry_out;
    endtask

    // One request; latency counts rising edges after the accepting edge.
    task automatic run_req(input bit sel, input logic [7:0] nn, input logic [7:0] qx,
                           input logic [7:0] qy, input int lat_exp, input logic [7:0] ex,
                           input logic [7:0] ey, input bit interfere, input string tag);
        int         lat;
        bit         found;
        logic       b, d;
        logic [7:0] rx, ry;
        @(negedge clk);
        drive(sel, 1'b1, nn, qx, qy);
        @(posedge clk);
        found = 1'b0;
        lat   = 999;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (interfere) drive(sel, 1'b1, 8'd3, 8'd10, 8'd6);
                else drive(sel, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
            end else if (k == 2) begin
                drive(sel, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
            end
            sample(sel, b, d, rx, ry);
            if (k == 1) check({tag, "_busy_t1"}, 32'(b), 32'd1);
            if (d) begin
                found = 1'b1;
                lat   = k;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        check({tag, "_rx"}, 32'(rx), 32'(ex));
        check({tag, "_ry"}, 32'(ry), 32'(ey));
        @(negedge clk);
        sample(sel, b, d, rx, ry);
        check({tag, "_busy_after"}, 32'(b), 32'd0);
        check({tag, "_done_after"}, 32'(d), 32'd0);
        check({tag, "_rx_hold"}, 32'(rx), 32'(ex));
    endtask

    initial begin
        logic       b, d;
        logic [7:0] rx, ry;
        int         gap;
        int         done_seen;
        checks = 0;
        passes = 0;

        // Reset held with start asserted: nothing may be accepted
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'd5, 8'd5, 8'd1);
        drive(1'b1, 1'b1, 8'd5, 8'd5, 8'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            sample(1'b0, b, d, rx, ry);
            check("rst_busy", 32'(b), 32'd0);
            check("rst_done", 32'(d), 32'd0);
            check("rst_rx", 32'(rx), 32'd0);
            check("rst_ry", 32'(ry), 32'd0);
            check("rst_busy_full", 32'(bus1.busy), 32'd0);
        end
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        rst = 1'b0;

        // Skip-leading-zeros instance, base point G
        run_req(1'b0, 8'd1,   8'd5, 8'd1, 3,  8'd5,  8'd1,  1'b0, "n1");
        run_req(1'b0, 8'd0,   8'd5, 8'd1, 1,  8'd0,  8'd0,  1'b0, "n0");
        run_req(1'b0, 8'd2,   8'd5, 8'd1, 4,  8'd6,  8'd3,  1'b0, "n2");
        run_req(1'b0, 8'd3,   8'd5, 8'd1, 5,  8'd10, 8'd6,  1'b0, "n3");
        run_req(1'b0, 8'd3,   8'd6, 8'd3, 5,  8'd16, 8'd13, 1'b0, "n3_q2g");
        run_req(1'b0, 8'hA5,  8'd5, 8'd1, 13, 8'd16, 8'd4,  1'b0, "nA5");

        // Full-width instance: 255 = 8 mod 19, 0xA5 = 13 mod 19
        run_req(1'b1, 8'hFF,  8'd5, 8'd1, 17, 8'd13, 8'd7,  1'b0, "full_nFF");
        run_req(1'b1, 8'h01,  8'd5, 8'd1, 10, 8'd5,  8'd1,  1'b0, "full_n01");
        run_req(1'b1, 8'h00,  8'd5, 8'd1, 9,  8'd0,  8'd0,  1'b0, "full_n00");

        // Second start while busy must not disturb the first request
        run_req(1'b0, 8'd2,   8'd5, 8'd1, 4,  8'd6,  8'd3,  1'b1, "ignore_busy");

        // start held high: next acceptance one idle cycle after each done
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd1, 8'd5, 8'd1);
        done_seen = 0;
        for (int k = 0; k < 40 && done_seen == 0; k++) begin
            @(negedge clk);
            if (bus0.done) done_seen = 1;
        end
        check("held_first_done", 32'(done_seen), 32'd1);
        @(negedge clk);
        check("held_idle_gap", 32'(bus0.busy), 32'd0);
        gap = 999;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (bus0.done) begin
                gap = k;
                break;
            end
        end
        check("held_done_spacing", 32'(gap), 32'd4);
        check("held_rx", 32'(bus0.Rx_out), 32'd5);
        check("held_ry", 32'(bus0.Ry_out), 32'd1);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        check("held_release_idle", 32'(bus0.busy), 32'd0);

        // Abort n=0xA5 while in DBL
        @(negedge clk);
        drive(1'b0, 1'b1, 8'hA5, 8'd5, 8'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sample(1'b0, b, d, rx, ry);
        check("abort_busy", 32'(b), 32'd0);
        check("abort_done", 32'(d), 32'd0);
        check("abort_rx", 32'(rx), 32'd0);
        check("abort_ry", 32'(ry), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus0.done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_req(1'b0, 8'hA5,  8'd5, 8'd1, 13, 8'd16, 8'd4,  1'b0, "after_abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/point_multiplier_seq.md
# point_multiplier_seq

Sequential elliptic-curve scalar multiplier: computes R = n·Q by MSB-first double-and-add, time-multiplexing a single `PointAdder` instance over one bit-step per cycle instead of a fully unrolled 2·WIDTH-adder cascade. It sits between the ElGamal encrypt/decrypt control logic and the point-arithmetic layer, accepting one request at a time under a start/busy/done handshake. The point at infinity is encoded as (0,0) throughout, matching `PointAdder`.

## Interface
- `WIDTH`, default `` `DATAWIDTH ``: bit width of the scalar and of each coordinate; must equal the width `PointAdder` is built for.
- `SKIP_LEADING_ZEROS`, default 1: 1 = begin iteration at the highest set bit of `n`; 0 = always iterate all WIDTH bits (constant doubling count).

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request strobe; sampled only when `busy`=0.
- `n` input WIDTH: scalar, captured on an accepted `start`.
- `Qx`, `Qy` input WIDTH: base point, captured on an accepted `start`.
- `busy` output 1: high from the cycle after acceptance until `done`, inclusive.
- `done` output 1: one-cycle pulse; result valid on `Rx_out`/`Ry_out` in that cycle.
- `Rx_out`, `Ry_out` output WIDTH: result registers; held until the next accepted `start`.

## Operation
- States: IDLE, DBL, ADD, FIN.
- IDLE: `busy`=0. `start`=1 latches n→N, (Qx,Qy)→(QX,QY), sets R=(0,0), sets `Rx_out`/`Ry_out`=(0,0), and sets idx:
  - `SKIP_LEADING_ZEROS`=0: idx=WIDTH−1, go to DBL.
  - `SKIP_LEADING_ZEROS`=1: idx = position of the highest set bit of n, go to DBL. If n=0, go directly to FIN with R=(0,0).
- DBL: R ← PointAdder(R,R). If N[idx]=1, go to ADD. Otherwise, if idx=0 go to FIN, else idx←idx−1 and stay in DBL.
- ADD: R ← PointAdder(R,(QX,QY)). If idx=0 go to FIN, else idx←idx−1 and go to DBL.
- FIN: `Rx_out`,`Ry_out` ← R. Assert `done`=1 for one cycle, then return to IDLE.
- Adder operand mux: DBL selects (R,R); ADD selects (R,Q). The adder output is captured only in DBL/ADD.
- All arithmetic is delegated to `PointAdder`, including modular reduction and the infinity cases. This block performs no field arithmetic and only mux, counter and priority-encode logic.
- idx width is clog2(WIDTH). The counter never wraps, because FIN is taken at idx=0.
- Inputs `n`,`Qx`,`Qy` may change freely after acceptance. Only latched copies are used.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `Rx_out`=0, `Ry_out`=0, and R, N, QX, QY, idx all 0.
- `rst` has priority over everything. Asserting it mid-operation aborts the computation with no `done`, and all registers take their reset values on the next edge.
- `start` while `busy`=1 is ignored; there is no queueing.
- `start` in the same cycle as `done` (FIN) is ignored. The earliest accept is the cycle after `done`.
- Acceptance at edge t gives `busy`=1 from t+1.
- Let m = number of bits iterated: WIDTH, or msb(n)+1 when skipping. Let p = popcount(n).
- DBL/ADD occupy m+p cycles. `done` is high in cycle t+1+m+p and `busy` falls after it.
- Special case: n=0 with skipping gives `done` at t+1.
- Worst case: n all-ones, 2·WIDTH+1 cycles from acceptance to `done`.
- One `PointAdder` evaluation per cycle sets the critical path, which is the adder plus a 2:1 operand mux.

## Test plan
- **Reset:** drive `rst`=1 for 2 cycles with `start`=1 → `busy`=0, `done`=0, outputs (0,0) throughout; no acceptance occurs.
- **Small scalars, WIDTH=8, SKIP=1:**
  - n=1, Q=G → `done` 3 cycles after acceptance, R=PointAdder((0,0),G)=G.
  - n=0 → `done` after 1 cycle, R=(0,0).
- **Doubling:** n=2 → R equals a single PointAdder(G,G) reference. Also n=3 → R=PointAdder(PointAdder(G,G),G). Check latencies of 4 and 5 cycles respectively.
- **Full scalar:**
  - n=8'hFF, SKIP=0 → `done` at cycle 17.
  - n=8'h01, SKIP=0 → `done` at cycle 10.
  - Both results must match a software double-and-add model using the same infinity=(0,0) convention.
- **Handshake:**
  - Pulse `start` with new operands while `busy`=1 → ignored; the result belongs to the first request.
  - `start` held continuously → back-to-back requests spaced one idle cycle after each `done`.
- **Abort:** assert `rst` mid-DBL for n=8'hA5 → no `done`. A subsequent clean request with n=8'hA5 produces the model result with the normal latency (8+4+1 cycles, SKIP=1).
